// File: rtl/cix32_mem_arbiter_if.sv
// cix32 memory arbiter bus bundle: fetch, data and unified memory port.
// master is the arbiter's view; slave is the core/memory side.
interface cix32_mem_arbiter_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      input  imem_req, imem_addr,
      input  dmem_req, dmem_we, dmem_addr,
      input  dmem_wdata, dmem_wstrb,
      input  mem_rdata, mem_ready,
      output imem_rdata, imem_ready,
      output dmem_rdata, dmem_ready,
      output mem_req, mem_we, mem_addr,
      output mem_wdata, mem_wstrb
   );

   modport slave (
      output imem_req, imem_addr,
      output dmem_req, dmem_we, dmem_addr,
      output dmem_wdata, dmem_wstrb,
      output mem_rdata, mem_ready,
      input  imem_rdata, imem_ready,
      input  dmem_rdata, dmem_ready,
      input  mem_req, mem_we, mem_addr,
      input  mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/cix32_mem_arbiter.sv
// cix32 unified memory arbiter: data priority, fetch anti-starvation
// cap, per-access timeout with error word. All outputs registered.
module cix32_mem_arbiter #(
   parameter int          MAX_D_STREAK = 4,
   parameter int          TIMEOUT_CYC  = 256,
   parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
   input  logic                clk,
   input  logic                rst,
   cix32_mem_arbiter_if.master bus,
   output logic [1:0]          owner,
   output logic                err_pulse,
   output logic [31:0]         err_addr,
   output logic [7:0]          err_count
);
   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam int TW = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      IDLE, I_ACC, D_ACC, DONE
   } state_t;

   typedef struct packed {
      state_t          st;
      logic [SW-1:0]   streak;
      logic [TW-1:0]   tcnt;
      logic            mem_req;
      logic            mem_we;
      logic [31:0]     mem_addr;
      logic [31:0]     mem_wdata;
      logic [3:0]      mem_wstrb;
      logic [31:0]     irdata;
      logic [31:0]     drdata;
      logic            iready;
      logic            dready;
      logic [1:0]      owner;
      logic            err_pulse;
      logic [31:0]     err_addr;
      logic [7:0]      err_count;
   } regs_t;

   regs_t cur;
   regs_t nxt;
   logic  d_win;
   logic  expire;
   logic  [31:0] rd;

   always_ff @(posedge clk) begin
      if (rst) cur <= '0;
      else     cur <= nxt;
   end

   assign d_win  = bus.dmem_req &&
                   (!bus.imem_req ||
                    cur.streak < SW'(MAX_D_STREAK));
   assign expire = cur.tcnt == TW'(TIMEOUT_CYC - 1);
   assign rd     = bus.mem_ready ? bus.mem_rdata : ERR_DATA;

   always_comb begin
      nxt = cur;
      unique case (cur.st)
         IDLE: begin
            if (d_win) begin
               nxt.st        = D_ACC;
               nxt.owner     = 2'b10;
               nxt.mem_req   = 1'b1;
               nxt.mem_we    = bus.dmem_we;
               nxt.mem_addr  = bus.dmem_addr;
               nxt.mem_wdata = bus.dmem_wdata;
               nxt.mem_wstrb = bus.dmem_we ?
                               bus.dmem_wstrb : 4'b0000;
               nxt.tcnt      = '0;
               nxt.streak    = bus.imem_req ?
                               cur.streak + 1'b1 : '0;
            end else if (bus.imem_req) begin
               nxt.st        = I_ACC;
               nxt.owner     = 2'b01;
               nxt.mem_req   = 1'b1;
               nxt.mem_we    = 1'b0;
               nxt.mem_addr  = bus.imem_addr;
               nxt.mem_wdata = '0;
               nxt.mem_wstrb = 4'b0000;
               nxt.tcnt      = '0;
               nxt.streak    = '0;
            end
         end
         I_ACC, D_ACC: begin
            if (bus.mem_ready || expire) begin
               nxt.st      = DONE;
               nxt.mem_req = 1'b0;
               if (cur.st == I_ACC) begin
                  nxt.irdata = rd;
                  nxt.iready = 1'b1;
               end else begin
                  nxt.drdata = rd;
                  nxt.dready = 1'b1;
               end
               // a late answer on the expiry edge still wins
               if (!bus.mem_ready) begin
                  nxt.err_pulse = 1'b1;
                  nxt.err_addr  = cur.mem_addr;
                  if (cur.err_count != 8'hFF)
                     nxt.err_count = cur.err_count + 8'd1;
               end
            end else begin
               nxt.tcnt = cur.tcnt + 1'b1;
            end
         end
         DONE: begin
            nxt.st        = IDLE;
            nxt.owner     = 2'b00;
            nxt.iready    = 1'b0;
            nxt.dready    = 1'b0;
            nxt.err_pulse = 1'b0;
         end
         default: nxt.st = IDLE;
      endcase
   end

   assign bus.mem_req    = cur.mem_req;
   assign bus.mem_we     = cur.mem_we;
   assign bus.mem_addr   = cur.mem_addr;
   assign bus.mem_wdata  = cur.mem_wdata;
   assign bus.mem_wstrb  = cur.mem_wstrb;
   assign bus.imem_rdata = cur.irdata;
   assign bus.imem_ready = cur.iready;
   assign bus.dmem_rdata = cur.drdata;
   assign bus.dmem_ready = cur.dready;
   assign owner          = cur.owner;
   assign err_pulse      = cur.err_pulse;
   assign err_addr       = cur.err_addr;
   assign err_count      = cur.err_count;
endmodule

// File: tb/tb_cix32_mem_arbiter.sv
// Self-checking bench for cix32_mem_arbiter: directed cases plus
// randomized accesses against a transaction-level memory/requester model.
module tb_cix32_mem_arbiter;
   localparam int          MAXD = 4;
   localparam int          TOUT = 8;
   localparam logic [31:0] ERRW = 32'hDEADBEEF;

   logic        clk;
   logic        rst;
   logic [1:0]  owner;
   logic        err_pulse;
   logic [31:0] err_addr;
   logic [7:0]  err_count;

   cix32_mem_arbiter_if bus ();

   cix32_mem_arbiter #(
      .MAX_D_STREAK (MAXD),
      .TIMEOUT_CYC  (TOUT),
      .ERR_DATA     (ERRW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .owner     (owner),
      .err_pulse (err_pulse),
      .err_addr  (err_addr),
      .err_count (err_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag,
                      input logic [95:0] got,
                      input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  own;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  ws;
   } acc_t;

   acc_t        log_q[$];
   acc_t        cur_acc;
   int          wait_n = 0;
   bit          silent = 0;
   bit          manual = 0;
   bit          active = 0;
   int          wcnt   = 0;
   logic [31:0] last_rd = '0;

   // memory model: logs each access, checks stability, answers after wait_n
   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (manual) continue;
         if (bus.mem_ready) begin
            bus.mem_ready = 1'b0;
            active = 0;
         end else if (bus.mem_req) begin
            if (!active) begin
               active = 1;
               wcnt = 0;
               cur_acc = '{owner, bus.mem_we, bus.mem_addr,
                           bus.mem_wdata, bus.mem_wstrb};
               log_q.push_back(cur_acc);
            end else begin
               chk("mem_stable",
                   {bus.mem_we, bus.mem_addr, bus.mem_wdata,
                    bus.mem_wstrb},
                   {cur_acc.we, cur_acc.addr, cur_acc.wdata,
                    cur_acc.ws});
            end
            if (!silent && wcnt == wait_n) begin
               last_rd = $urandom;
               bus.mem_rdata = last_rd;
               bus.mem_ready = 1'b1;
            end else begin
               wcnt++;
            end
         end else begin
            active = 0;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ready(input bit d, output bit ok,
                             output int lat, output int mcyc);
      ok = 0;
      lat = 0;
      mcyc = 0;
      while (!ok && lat < 400) begin
         tick();
         lat++;
         if (bus.mem_req) mcyc++;
         if (d ? bus.dmem_ready : bus.imem_ready) ok = 1;
      end
      if (!ok) chk("ready_bound", 0, 1);
   endtask

   task automatic access(input bit d, input bit we,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         input logic [3:0] ws,
                         output logic [31:0] rd,
                         output int lat, output int mcyc);
      bit ok;
      if (d) begin
         bus.dmem_req   = 1'b1;
         bus.dmem_we    = we;
         bus.dmem_addr  = a;
         bus.dmem_wdata = wd;
         bus.dmem_wstrb = ws;
      end else begin
         bus.imem_req  = 1'b1;
         bus.imem_addr = a;
      end
      wait_ready(d, ok, lat, mcyc);
      rd = d ? bus.dmem_rdata : bus.imem_rdata;
      bus.imem_req = 1'b0;
      bus.dmem_req = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input acc_t e);
      acc_t g;
      if (log_q.size() == 0) begin
         chk({tag, "_logged"}, 0, 1);
      end else begin
         g = log_q.pop_front();
         chk({tag, "_own"}, g.own, e.own);
         chk({tag, "_we"}, g.we, e.we);
         chk({tag, "_addr"}, g.addr, e.addr);
         if (e.we) chk({tag, "_wdata"}, g.wdata, e.wdata);
         chk({tag, "_wstrb"}, g.ws, e.ws);
      end
   endtask

   logic [31:0] rd;
   int          lat;
   int          mcyc;
   bit          ok;
   bit          seen;
   string       seq;
   string       eseq;

   initial begin
      rst = 1'b1;
      bus.imem_req   = 0;
      bus.imem_addr  = 0;
      bus.dmem_req   = 0;
      bus.dmem_we    = 0;
      bus.dmem_addr  = 0;
      bus.dmem_wdata = 0;
      bus.dmem_wstrb = 0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_owner", owner, 0);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_ready", {bus.imem_ready, bus.dmem_ready}, 0);
      chk("rst_err", {err_pulse, err_count, err_addr}, 0);

      // single zero-wait fetch
      wait_n = 0;
      access(0, 0, 32'h10, 0, 0, rd, lat, mcyc);
      chk("f1_rdata", rd, last_rd);
      chk("f1_lat", lat, 2);
      chk("f1_owner", owner, 2'b01);
      pop_chk("f1", '{2'b01, 1'b0, 32'h10, 0, 4'b0});
      tick();
      chk("f1_owner_clr", owner, 0);
      chk("f1_pulse", bus.imem_ready, 0);

      // request held through ready: no grant during DONE
      bus.dmem_req  = 1;
      bus.dmem_we   = 0;
      bus.dmem_addr = 32'h300;
      wait_ready(1, ok, lat, mcyc);
      tick();
      chk("h_idle_req", {bus.mem_req, owner}, 0);
      chk("h_idle_rdy", bus.dmem_ready, 0);
      tick();
      chk("h_regrant", {bus.mem_req, owner}, {1'b1, 2'b10});
      wait_ready(1, ok, lat, mcyc);
      bus.dmem_req = 0;
      chk("h_grants", log_q.size(), 2);
      log_q.delete();

      // write with strobes, two wait states
      wait_n = 2;
      access(1, 1, 32'h1004, 32'h12345678, 4'b0101, rd, lat, mcyc);
      chk("w_rdy_owner", owner, 2'b10);
      chk("w_mcyc", mcyc, 3);
      pop_chk("w", '{2'b10, 1'b1, 32'h1004, 32'h12345678, 4'b0101});
      tick();
      chk("w_pulse", bus.dmem_ready, 0);

      // both held: D x MAXD then I, repeating
      wait_n = 0;
      bus.imem_req  = 1;
      bus.imem_addr = 32'h100;
      bus.dmem_req  = 1;
      bus.dmem_we   = 0;
      bus.dmem_addr = 32'h200;
      for (int i = 0; i < 300 && log_q.size() < 10; i++) begin
         tick();
         if (bus.imem_ready) bus.imem_addr += 4;
         if (bus.dmem_ready) bus.dmem_addr += 4;
      end
      bus.imem_req = 0;
      bus.dmem_req = 0;
      seq  = "";
      eseq = "";
      for (int i = 0; i < 10; i++) begin
         eseq = {eseq, (i % (MAXD + 1) == MAXD) ? "I" : "D"};
         if (i < log_q.size())
            seq = {seq, (log_q[i].own == 2'b01) ? "I" : "D"};
      end
      checks++;
      if (seq != eseq) begin
         failures++;
         $display("FAIL grant_order got=%s exp=%s", seq, eseq);
      end
      for (int i = 0; i < 8; i++) tick();
      chk("prio_idle", {bus.mem_req, owner}, 0);
      log_q.delete();

      // unanswered access times out
      silent = 1;
      access(1, 0, 32'hABC0, 0, 0, rd, lat, mcyc);
      chk("to_mcyc", mcyc, TOUT);
      chk("to_rdata", rd, ERRW);
      chk("to_pulse", err_pulse, 1);
      chk("to_addr", err_addr, 32'hABC0);
      chk("to_count", err_count, 1);
      tick();
      chk("to_pulse_clr", err_pulse, 0);

      // error counter saturation
      for (int i = 0; i < 255; i++)
         access(0, 0, 32'h4000 + i * 4, 0, 0, rd, lat, mcyc);
      chk("sat_count", err_count, 8'hFF);
      chk("sat_addr", err_addr, 32'h4000 + 254 * 4);
      chk("sat_rdata", rd, ERRW);
      silent = 0;
      log_q.delete();

      // reset in the middle of a wait-state access
      wait_n = 5;
      bus.dmem_req  = 1;
      bus.dmem_we   = 0;
      bus.dmem_addr = 32'h5550;
      for (int i = 0; i < 10 && !bus.mem_req; i++) tick();
      tick();
      rst = 1;
      tick();
      rst = 0;
      bus.dmem_req = 0;
      chk("mr_req", bus.mem_req, 0);
      chk("mr_owner", owner, 0);
      chk("mr_err", err_count, 0);
      manual = 1;
      bus.mem_rdata = 32'h0BAD0BAD;
      bus.mem_ready = 1;
      tick();
      bus.mem_ready = 0;
      manual = 0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.dmem_ready || bus.imem_ready || bus.mem_req)
            seen = 1;
         tick();
      end
      chk("mr_no_ready", seen, 0);
      log_q.delete();

      // randomized single accesses
      for (int i = 0; i < 60; i++) begin
         automatic bit          d  = 1'($urandom);
         automatic bit          we = d & 1'($urandom);
         automatic logic [31:0] a  = $urandom & 32'hFFFF_FFFC;
         automatic logic [31:0] wd = $urandom;
         automatic logic [3:0]  ws = 4'($urandom);
         wait_n = $urandom_range(0, 3);
         access(d, we, a, wd, ws, rd, lat, mcyc);
         chk("r_rdata", rd, last_rd);
         chk("r_mcyc", mcyc, wait_n + 1);
         chk("r_err", err_pulse, 0);
         pop_chk("r", '{d ? 2'b10 : 2'b01, we, a, wd,
                        we ? ws : 4'b0000});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
